// File: rtl/lockin_demod.sv
// lockin_demod: PWM-synchronous lock-in demodulator that sums ADC samples per PWM phase over 2**PERIODS_LOG2 periods.
// Optional feature macro LOCKIN_DEMOD_BLANK_EN drops BLANK_SAMPLES valid samples after every PWM edge.
module lockin_demod #(
  parameter int DATA_W        = 12,
  parameter int PERIODS_LOG2  = 3,
  parameter int ACC_W         = 32,
  parameter int CNT_W         = 16,
  parameter int BLANK_SAMPLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [DATA_W-1:0]     sample_data,
  input  logic                  pwm_ref,
  output logic                  demod_valid,
  output logic signed [ACC_W:0] demod_out,
  output logic [CNT_W-1:0]      on_count,
  output logic [CNT_W-1:0]      off_count,
  output logic                  overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

  localparam logic [PERIODS_LOG2-1:0] PER_LAST = {PERIODS_LOG2{1'b1}};

  if (ACC_W < DATA_W || PERIODS_LOG2 < 1 || BLANK_SAMPLES < 0) begin : g_bad_cfg
    $error("lockin_demod: ACC_W must cover DATA_W, PERIODS_LOG2 >= 1, BLANK_SAMPLES >= 0");
  end

  state_t                  state_r;
  logic                    pwm_meta_r;
  logic                    pwm_s_r;
  logic                    pwm_d_r;
  logic [PERIODS_LOG2-1:0] period_cnt_r;
  logic [ACC_W-1:0]        on_sum_r;
  logic [ACC_W-1:0]        off_sum_r;
  logic [CNT_W-1:0]        on_cnt_r;
  logic [CNT_W-1:0]        off_cnt_r;
  logic                    ovf_frame_r;

  logic             rise_s;
  logic             close_s;
  logic             take_s;
  logic [ACC_W:0]   sample_ext_s;
  logic [ACC_W:0]   add_s;
  logic [ACC_W-1:0] on_sum_nx_s;
  logic [ACC_W-1:0] off_sum_nx_s;
  logic [ACC_W-1:0] sel_sum_s;
  logic [ACC_W-1:0] sum_sat_s;
  logic [CNT_W-1:0] on_cnt_nx_s;
  logic [CNT_W-1:0] off_cnt_nx_s;
  logic [CNT_W-1:0] sel_cnt_s;
  logic [CNT_W-1:0] cnt_sat_s;
  logic             ovf_nx_s;

  assign rise_s       = pwm_s_r & ~pwm_d_r;
  assign close_s      = (state_r == ACCUM) & rise_s & (period_cnt_r == PER_LAST);
  assign sample_ext_s = {{(ACC_W + 1 - DATA_W){1'b0}}, sample_data};

`ifdef LOCKIN_DEMOD_BLANK_EN
  localparam int                 BLANK_W = $clog2(BLANK_SAMPLES + 2);
  localparam logic [BLANK_W-1:0] BLANK_N = BLANK_W'(BLANK_SAMPLES);

  logic [BLANK_W-1:0] blank_cnt_r;
  logic [BLANK_W-1:0] blank_left_s;

  // A sample arriving on the edge cycle is already post-edge, so it is the first one blanked.
  assign blank_left_s = (pwm_s_r ^ pwm_d_r) ? BLANK_N : blank_cnt_r;
  assign take_s       = sample_valid & (blank_left_s == '0);

  // Blank counter: reloaded by every PWM edge, decremented per discarded valid sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_cnt_r <= '0;
    end else if (sample_valid && (blank_left_s != '0)) begin
      blank_cnt_r <= blank_left_s - BLANK_W'(1);
    end else begin
      blank_cnt_r <= blank_left_s;
    end
  end
`else
  assign take_s = sample_valid;
`endif

  // PWM synchroniser plus edge-detect flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_meta_r <= 1'b0;
      pwm_s_r    <= 1'b0;
      pwm_d_r    <= 1'b0;
    end else begin
      pwm_meta_r <= pwm_ref;
      pwm_s_r    <= pwm_meta_r;
      pwm_d_r    <= pwm_s_r;
    end
  end

  // Next sums/counts: a closing edge starts the new frame from zero before its own sample is applied.
  always_comb begin
    on_sum_nx_s  = close_s ? '0 : on_sum_r;
    off_sum_nx_s = close_s ? '0 : off_sum_r;
    on_cnt_nx_s  = close_s ? '0 : on_cnt_r;
    off_cnt_nx_s = close_s ? '0 : off_cnt_r;
    ovf_nx_s     = close_s ? 1'b0 : ovf_frame_r;
    sel_sum_s    = pwm_s_r ? on_sum_nx_s : off_sum_nx_s;
    sel_cnt_s    = pwm_s_r ? on_cnt_nx_s : off_cnt_nx_s;
    add_s        = {1'b0, sel_sum_s} + sample_ext_s;
    sum_sat_s    = add_s[ACC_W] ? {ACC_W{1'b1}} : add_s[ACC_W-1:0];
    cnt_sat_s    = (&sel_cnt_s) ? sel_cnt_s : sel_cnt_s + CNT_W'(1);
    if (take_s) begin
      ovf_nx_s = ovf_nx_s | add_s[ACC_W] | (&sel_cnt_s);
      if (pwm_s_r) begin
        on_sum_nx_s = sum_sat_s;
        on_cnt_nx_s = cnt_sat_s;
      end else begin
        off_sum_nx_s = sum_sat_s;
        off_cnt_nx_s = cnt_sat_s;
      end
    end else begin
      ovf_nx_s = ovf_nx_s;
    end
  end

  // Frame FSM and result registers; DONE is the one cycle in which demod_valid is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      period_cnt_r <= '0;
      on_sum_r     <= '0;
      off_sum_r    <= '0;
      on_cnt_r     <= '0;
      off_cnt_r    <= '0;
      ovf_frame_r  <= 1'b0;
      demod_valid  <= 1'b0;
      demod_out    <= '0;
      on_count     <= '0;
      off_count    <= '0;
      overflow     <= 1'b0;
    end else begin
      demod_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_r      <= ACCUM;
            period_cnt_r <= '0;
            on_sum_r     <= '0;
            off_sum_r    <= '0;
            on_cnt_r     <= '0;
            off_cnt_r    <= '0;
            ovf_frame_r  <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCUM, DONE: begin
          on_sum_r    <= on_sum_nx_s;
          off_sum_r   <= off_sum_nx_s;
          on_cnt_r    <= on_cnt_nx_s;
          off_cnt_r   <= off_cnt_nx_s;
          ovf_frame_r <= ovf_nx_s;
          if (close_s) begin
            state_r      <= DONE;
            period_cnt_r <= '0;
            demod_valid  <= 1'b1;
            demod_out    <= {1'b0, on_sum_r} - {1'b0, off_sum_r};
            on_count     <= on_cnt_r;
            off_count    <= off_cnt_r;
            overflow     <= ovf_frame_r;
          end else begin
            state_r <= ACCUM;
            if (rise_s) begin
              period_cnt_r <= period_cnt_r + PERIODS_LOG2'(1);
            end else begin
              period_cnt_r <= period_cnt_r;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
